key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/key_debounce_stable_timer.sv | 18 +
 rtl/key_debounce.sv | 82 ++++++++
 tb/tb_key_debounce.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: state encoding and timer sizing shared by the debounce stage
package key_debounce_pkg;
  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } state_t;
  function automatic int tmr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce_stable_timer.sv
// stable_timer: counts consecutive qualifying samples, done at STABLE_CYCLES-1
module stable_timer
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);
  localparam int W = tmr_width(STABLE_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign done = cnt_q == W'(STABLE_CYCLES - 1);
endmodule

// File: rtl/key_debounce.sv
// key_debounce: qualifies a synchronized key level and emits level, press/release pulses and a press count
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic                 level,
  output logic                 press,
  output logic                 release_pulse,
  output logic [CNT_WIDTH-1:0] count
);
  state_t state_q, state_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic clear, inc, done;
  stable_timer #(.STABLE_CYCLES(STABLE_CYCLES)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (inc),
    .done (done)
  );
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    clear     = 1'b0;
    inc       = 1'b0;
    case (state_q)
      LOW: if (in) begin
        state_d = RISE_CHK;
        inc     = 1'b1;
      end
      RISE_CHK: if (!in) begin
        state_d = LOW;
        clear   = 1'b1;
      end else if (done) begin
        state_d = HIGH;
        level_d = 1'b1;
        press_d = 1'b1;
        count_d = count_q + CNT_WIDTH'(1);
        clear   = 1'b1;
      end else inc = 1'b1;
      HIGH: if (!in) begin
        state_d = FALL_CHK;
        inc     = 1'b1;
      end
      FALL_CHK: if (in) begin
        state_d = HIGH;
        clear   = 1'b1;
      end else if (done) begin
        state_d   = LOW;
        level_d   = 1'b0;
        release_d = 1'b1;
        clear     = 1'b1;
      end else inc = 1'b1;
      default: begin
        state_d = LOW;
        level_d = 1'b0;
        count_d = '0;
        clear   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    state_q   <= reset ? LOW : state_d;
    level_q   <= reset ? 1'b0 : level_d;
    press_q   <= reset ? 1'b0 : press_d;
    release_q <= reset ? 1'b0 : release_d;
    count_q   <= reset ? '0 : count_d;
  end
  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign count         = count_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: run-length reference model plus directed scenarios for key_debounce
module tb_key_debounce;
  localparam int SC = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b0;
  logic level, press, rel;
  logic [CW-1:0] count;
  int checks = 0;
  int failures = 0;
  int n_press = 0;
  int n_rel = 0;
  bit live = 1'b0;
  int m_run = 0;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel = 1'b0;
  logic [CW-1:0] m_count = '0;
  key_debounce #(.STABLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .level        (level),
    .press        (press),
    .release_pulse(rel),
    .count        (count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic r);
    in    = v;
    reset = r;
    @(posedge clk);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      m_run   = 0;
      m_level = 1'b0;
      m_count = '0;
    end else if (v != m_level) begin
      m_run++;
      if (m_run == SC) begin
        m_level = v;
        m_run   = 0;
        if (v) begin
          m_press = 1'b1;
          m_count = m_count + CW'(1);
        end else m_rel = 1'b1;
      end
    end else m_run = 0;
    live = 1'b1;
    #1;
  endtask
  task automatic rst_seq();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    n_press = 0;
    n_rel   = 0;
  endtask
  always @(negedge clk) if (live) begin
    chk("model_level", level, m_level);
    chk("model_press", press, m_press);
    chk("model_release", rel, m_rel);
    chk("model_count", count, m_count);
    chk("press_release_exclusive", press & rel, 1'b0);
    n_press += int'(press);
    n_rel   += int'(rel);
  end
  initial begin
    rst_seq();
    chk("reset_level", level, 1'b0);
    chk("reset_count", count, 0);
    repeat (10) step(1'b0, 1'b0);
    chk("idle_press_n", n_press, 0);
    chk("idle_release_n", n_rel, 0);
    chk("idle_level", level, 1'b0);
    chk("idle_count", count, 0);
    rst_seq();
    for (int k = 1; k <= 30; k++) begin
      step(k >= 5 && k < 20, 1'b0);
      if (k == 7) chk("rise_early_press", press, 1'b0);
      if (k == 7) chk("rise_early_level", level, 1'b0);
      if (k == 8) chk("rise_press", press, 1'b1);
      if (k == 8) chk("rise_level", level, 1'b1);
      if (k == 8) chk("rise_count", count, 1);
      if (k == 9) chk("rise_press_width", press, 1'b0);
      if (k == 22) chk("fall_early_level", level, 1'b1);
      if (k == 23) chk("fall_release", rel, 1'b1);
      if (k == 23) chk("fall_level", level, 1'b0);
      if (k == 23) chk("fall_count", count, 1);
      if (k == 24) chk("fall_release_width", rel, 1'b0);
    end
    rst_seq();
    for (int k = 1; k <= 16; k++) begin
      step(k >= 5 && k != 8, 1'b0);
      if (k == 7) chk("glitch_short_run_press", press, 1'b0);
      if (k == 11) chk("glitch_restart_early", press, 1'b0);
      if (k == 12) chk("glitch_press", press, 1'b1);
      if (k == 12) chk("glitch_count", count, 1);
    end
    rst_seq();
    for (int k = 0; k < 50; k++) step(k[0], 1'b0);
    chk("toggle_press_n", n_press, 0);
    chk("toggle_release_n", n_rel, 0);
    chk("toggle_level", level, 1'b0);
    chk("toggle_count", count, 0);
    rst_seq();
    for (int i = 1; i <= 17; i++) begin
      repeat (5) step(1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0);
      chk("wrap_count", count, i % 16);
    end
    chk("wrap_final_count", count, 1);
    chk("wrap_press_n", n_press, 17);
    chk("wrap_release_n", n_rel, 17);
    rst_seq();
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, k == 10);
      if (k == 4) chk("pre_reset_press", press, 1'b1);
      if (k == 9) chk("pre_reset_level", level, 1'b1);
      if (k == 10) chk("forced_drop_level", level, 1'b0);
      if (k == 10) chk("forced_drop_release", rel, 1'b0);
      if (k == 10) chk("forced_drop_count", count, 0);
      if (k == 13) chk("rearm_early_press", press, 1'b0);
      if (k == 14) chk("rearm_press", press, 1'b1);
      if (k == 14) chk("rearm_count", count, 1);
    end
    chk("rearm_release_n", n_rel, 0);
    chk("rearm_press_n", n_press, 2);
    live = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
